// File: rtl/ov_dvp_capture.sv
// DVP camera capture front end: registers the sensor bus, skips settling frames,
// then packs byte pairs into RGB565 words with frame strobes and sticky geometry flags.
module ov_dvp_capture #(
   parameter int   WAIT_FRAMES = 10,
   parameter int   H_PIXELS    = 640,
   parameter int   V_LINES     = 480,
   parameter logic VS_POL      = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        camera_rstn,
   input  logic        cam_vsync,
   input  logic        cam_href,
   input  logic [7:0]  cam_data,
   output logic        camera_en,
   output logic [15:0] camera_data,
   output logic        frame_start,
   output logic        frame_done,
   output logic        capturing,
   output logic        line_err,
   output logic        frame_err
);

   localparam int PIX_W  = $clog2(H_PIXELS + 1);
   localparam int LINE_W = $clog2(V_LINES + 1);
   localparam int WAIT_W = $clog2(WAIT_FRAMES + 1);

   localparam logic [PIX_W-1:0]  PIX_EXP   = PIX_W'(H_PIXELS);
   localparam logic [LINE_W-1:0] LINE_EXP  = LINE_W'(V_LINES);
   localparam logic [WAIT_W-1:0] WAIT_DONE = WAIT_W'(WAIT_FRAMES);

   localparam logic [0:0] ST_WAIT_STABLE = 1'b0;
   localparam logic [0:0] ST_CAPTURE     = 1'b1;

   logic              r_vsync;
   logic              r_href;
   logic [7:0]        r_data;
   logic              r_vs_act_d;
   logic              r_href_q_d;

   logic [0:0]        r_state;
   logic [WAIT_W-1:0] r_wait_cnt;
   logic [PIX_W-1:0]  r_pix_cnt;
   logic [LINE_W-1:0] r_line_cnt;
   logic              r_phase;
   logic [7:0]        r_hi;
   logic              r_camera_en;
   logic [15:0]       r_camera_data;
   logic              r_frame_start;
   logic              r_frame_done;
   logic              r_line_err;
   logic              r_frame_err;

   logic              w_vs_act;
   logic              w_href_q;
   logic              w_fs_edge;
   logic              w_fe_edge;
   logic              w_href_fall;
   logic [PIX_W-1:0]  w_pix_inc;
   logic [LINE_W-1:0] w_line_nxt;

   // href is only meaningful outside the vsync pulse; its fall closes a line
   assign w_vs_act    = (r_vsync == VS_POL);
   assign w_href_q    = r_href & ~w_vs_act;
   assign w_fs_edge   = r_vs_act_d & ~w_vs_act;
   assign w_fe_edge   = ~r_vs_act_d & w_vs_act;
   assign w_href_fall = r_href_q_d & ~w_href_q;

   assign w_pix_inc  = (r_pix_cnt == '1) ? r_pix_cnt : r_pix_cnt + PIX_W'(1);
   // a line closing on the same edge as the frame end still belongs to that frame
   assign w_line_nxt = (w_href_fall && r_line_cnt != '1) ? r_line_cnt + LINE_W'(1) : r_line_cnt;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vsync    <= 1'b0;
         r_href     <= 1'b0;
         r_data     <= 8'd0;
         r_vs_act_d <= 1'b0;
         r_href_q_d <= 1'b0;
      end else begin
         r_vsync    <= cam_vsync;
         r_href     <= cam_href;
         r_data     <= cam_data;
         r_vs_act_d <= w_vs_act;
         r_href_q_d <= w_href_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_WAIT_STABLE;
         r_wait_cnt    <= '0;
         r_pix_cnt     <= '0;
         r_line_cnt    <= '0;
         r_phase       <= 1'b0;
         r_hi          <= 8'd0;
         r_camera_en   <= 1'b0;
         r_camera_data <= 16'd0;
         r_frame_start <= 1'b0;
         r_frame_done  <= 1'b0;
         r_line_err    <= 1'b0;
         r_frame_err   <= 1'b0;
      end else if (!camera_rstn) begin
         r_state       <= ST_WAIT_STABLE;
         r_wait_cnt    <= '0;
         r_pix_cnt     <= '0;
         r_line_cnt    <= '0;
         r_phase       <= 1'b0;
         r_hi          <= 8'd0;
         r_camera_en   <= 1'b0;
         r_camera_data <= 16'd0;
         r_frame_start <= 1'b0;
         r_frame_done  <= 1'b0;
         r_line_err    <= 1'b0;
         r_frame_err   <= 1'b0;
      end else begin
         r_camera_en   <= 1'b0;
         r_frame_start <= 1'b0;
         r_frame_done  <= 1'b0;
         case (r_state)
            ST_WAIT_STABLE: begin
               if (w_fs_edge) begin
                  if (r_wait_cnt == WAIT_DONE) begin
                     r_state       <= ST_CAPTURE;
                     r_frame_start <= 1'b1;
                     r_line_cnt    <= '0;
                     r_pix_cnt     <= '0;
                     r_phase       <= 1'b0;
                  end else begin
                     r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
                  end
               end
            end
            ST_CAPTURE: begin
               if (w_href_q) begin
                  if (!r_phase) begin
                     r_hi    <= r_data;
                     r_phase <= 1'b1;
                  end else begin
                     r_camera_data <= {r_hi, r_data};
                     r_camera_en   <= 1'b1;
                     r_pix_cnt     <= w_pix_inc;
                     r_phase       <= 1'b0;
                  end
               end
               if (w_href_fall) begin
                  if (r_phase || r_pix_cnt != PIX_EXP) r_line_err <= 1'b1;
                  r_pix_cnt <= '0;
                  r_phase   <= 1'b0;
               end
               if (w_fe_edge) begin
                  r_frame_done <= 1'b1;
                  if (w_line_nxt != LINE_EXP) r_frame_err <= 1'b1;
               end
               if (w_fs_edge) begin
                  r_line_cnt    <= '0;
                  r_frame_start <= 1'b1;
               end else begin
                  r_line_cnt <= w_line_nxt;
               end
            end
            default: r_state <= ST_WAIT_STABLE;
         endcase
      end
   end

   assign camera_en   = r_camera_en;
   assign camera_data = r_camera_data;
   assign frame_start = r_frame_start;
   assign frame_done  = r_frame_done;
   assign capturing   = (r_state == ST_CAPTURE);
   assign line_err    = r_line_err;
   assign frame_err   = r_frame_err;

endmodule

// File: tb/tb_ov_dvp_capture.sv
// Randomised bench for ov_dvp_capture: a frame-level model predicts pixels,
// strobe counts and sticky flags from the frame geometry driven on the DVP bus.
module tb_ov_dvp_capture;

   localparam int WAIT_FRAMES = 2;
   localparam int H_PIXELS    = 4;
   localparam int V_LINES     = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        camera_rstn;
   logic        cam_vsync;
   logic        cam_href;
   logic [7:0]  cam_data;
   logic        camera_en;
   logic [15:0] camera_data;
   logic        frame_start;
   logic        frame_done;
   logic        capturing;
   logic        line_err;
   logic        frame_err;

   ov_dvp_capture #(
      .WAIT_FRAMES (WAIT_FRAMES),
      .H_PIXELS    (H_PIXELS),
      .V_LINES     (V_LINES),
      .VS_POL      (1'b1)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .camera_rstn (camera_rstn),
      .cam_vsync   (cam_vsync),
      .cam_href    (cam_href),
      .cam_data    (cam_data),
      .camera_en   (camera_en),
      .camera_data (camera_data),
      .frame_start (frame_start),
      .frame_done  (frame_done),
      .capturing   (capturing),
      .line_err    (line_err),
      .frame_err   (frame_err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always @(posedge clk) cyc++;

   // observed traffic
   logic [15:0] got_pix[$];
   int          got_cyc[$];
   int          got_fs = 0;
   int          got_fd = 0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (camera_en) begin
            got_pix.push_back(camera_data);
            got_cyc.push_back(cyc);
         end
         if (frame_start) got_fs++;
         if (frame_done)  got_fd++;
      end
   end

   // frame-level reference model
   logic [15:0] exp_pix[$];
   int          exp_fs = 0;
   int          exp_fd = 0;
   int          fs_seen = 0;
   int          m_lines = 0;
   bit          m_cap = 1'b0;
   bit          m_line_err = 1'b0;
   bit          m_frame_err = 1'b0;
   bit          force_1234 = 1'b0;
   int          drv_cyc = 0;

   function automatic void model_restart();
      fs_seen     = 0;
      m_cap       = 1'b0;
      m_line_err  = 1'b0;
      m_frame_err = 1'b0;
      m_lines     = 0;
   endfunction

   function automatic void clear_log();
      got_pix.delete();
      got_cyc.delete();
      exp_pix.delete();
      got_fs = 0;
      got_fd = 0;
      exp_fs = 0;
      exp_fd = 0;
   endfunction

   function automatic int pix_diff();
      int n = (got_pix.size() < exp_pix.size()) ? got_pix.size() : exp_pix.size();
      for (int i = 0; i < n; i++) if (got_pix[i] !== exp_pix[i]) return i;
      return -1;
   endfunction

   task automatic send_line(input int nbytes);
      logic [7:0] b;
      logic [7:0] hi;
      hi = 8'd0;
      for (int i = 0; i < nbytes; i++) begin
         @(negedge clk);
         b = 8'($urandom_range(0, 255));
         if (force_1234 && i < 2) begin
            b = (i == 0) ? 8'h12 : 8'h34;
            if (i == 1) drv_cyc = cyc;
         end
         cam_href = 1'b1;
         cam_data = b;
         if (i % 2 == 0) hi = b;
         else if (m_cap) exp_pix.push_back({hi, b});
      end
      force_1234 = 1'b0;
      if (m_cap && (nbytes % 2 != 0 || nbytes / 2 != H_PIXELS)) m_line_err = 1'b1;
      m_lines++;
      @(negedge clk);
      cam_href = 1'b0;
      cam_data = 8'd0;
      repeat (3) @(negedge clk);
   endtask

   // vsync pulse: its rising edge ends the open frame, its falling edge opens the next
   task automatic send_vsync();
      if (m_cap) begin
         exp_fd++;
         if (m_lines != V_LINES) m_frame_err = 1'b1;
      end
      @(negedge clk);
      cam_vsync = 1'b1;
      repeat (2) @(negedge clk);
      cam_vsync = 1'b0;
      fs_seen++;
      if (fs_seen > WAIT_FRAMES) begin
         m_cap = 1'b1;
         exp_fs++;
      end
      m_lines = 0;
      repeat (3) @(negedge clk);
   endtask

   task automatic send_frame(input int n_lines, input int short_line);
      for (int l = 0; l < n_lines; l++)
         send_line((l == short_line) ? 2 * H_PIXELS - 1 : 2 * H_PIXELS);
      send_vsync();
   endtask

   task automatic test_reset();
      rst_n       = 1'b0;
      camera_rstn = 1'b1;
      cam_vsync   = 1'b0;
      cam_href    = 1'b0;
      cam_data    = 8'd0;
      repeat (3) @(negedge clk);
      checks++;
      if (camera_en !== 1'b0) begin
         errors++; $display("FAIL reset_camera_en: got %b expected 0", camera_en);
      end
      checks++;
      if (camera_data !== 16'd0) begin
         errors++; $display("FAIL reset_camera_data: got %h expected 0000", camera_data);
      end
      checks++;
      if ({frame_start, frame_done, capturing, line_err, frame_err} !== 5'b0) begin
         errors++;
         $display("FAIL reset_status: got %b expected 00000",
                  {frame_start, frame_done, capturing, line_err, frame_err});
      end
      rst_n = 1'b1;
      model_restart();
      repeat (4) @(negedge clk);
   endtask

   task automatic test_basic();
      clear_log();
      send_vsync();
      send_frame(2, -1);
      checks++;
      if (capturing !== 1'b0) begin
         errors++; $display("FAIL basic_wait_capturing: got %b expected 0", capturing);
      end
      send_frame(2, -1);
      checks++;
      if (got_pix.size() !== 0) begin
         errors++; $display("FAIL basic_discard_pixels: got %0d expected 0", got_pix.size());
      end
      checks++;
      if (capturing !== m_cap) begin
         errors++; $display("FAIL basic_enter_capture: got %b expected %b", capturing, m_cap);
      end
      force_1234 = m_cap;
      send_frame(2, -1);
      send_frame(2, -1);
      checks++;
      if (got_pix.size() !== exp_pix.size()) begin
         errors++;
         $display("FAIL basic_pixel_count: got %0d expected %0d", got_pix.size(), exp_pix.size());
      end
      checks++;
      if (pix_diff() != -1) begin
         errors++;
         $display("FAIL basic_pixel_data: index %0d got %h expected %h",
                  pix_diff(), got_pix[pix_diff()], exp_pix[pix_diff()]);
      end
      checks++;
      if (got_pix.size() == 0 || got_pix[0] !== 16'h1234) begin
         errors++; $display("FAIL basic_first_pixel: got %h expected 1234",
                            (got_pix.size() == 0) ? 16'hxxxx : got_pix[0]);
      end
      checks++;
      if (got_cyc.size() == 0 || got_cyc[0] - drv_cyc !== 2) begin
         errors++; $display("FAIL basic_latency: got %0d expected 2",
                            (got_cyc.size() == 0) ? -1 : got_cyc[0] - drv_cyc);
      end
      checks++;
      if (got_fs !== exp_fs || got_fd !== exp_fd) begin
         errors++; $display("FAIL basic_strobes: got fs=%0d fd=%0d expected fs=%0d fd=%0d",
                            got_fs, got_fd, exp_fs, exp_fd);
      end
      checks++;
      if ({line_err, frame_err} !== {m_line_err, m_frame_err}) begin
         errors++; $display("FAIL basic_errors: got %b%b expected %b%b",
                            line_err, frame_err, m_line_err, m_frame_err);
      end
   endtask

   task automatic test_back_to_back();
      clear_log();
      for (int f = 0; f < 3; f++) begin
         send_frame(2, -1);
         checks++;
         if (capturing !== 1'b1 || got_pix.size() !== exp_pix.size()) begin
            errors++;
            $display("FAIL b2b_frame%0d: got cap=%b pix=%0d expected cap=1 pix=%0d",
                     f, capturing, got_pix.size(), exp_pix.size());
         end
      end
      checks++;
      if (got_fs !== exp_fs || got_fd !== exp_fd) begin
         errors++; $display("FAIL b2b_strobes: got fs=%0d fd=%0d expected fs=%0d fd=%0d",
                            got_fs, got_fd, exp_fs, exp_fd);
      end
      checks++;
      if (pix_diff() != -1) begin
         errors++; $display("FAIL b2b_pixel_data: mismatch at index %0d", pix_diff());
      end
   endtask

   task automatic test_frame_err();
      clear_log();
      send_frame(3, -1);
      checks++;
      if (frame_err !== m_frame_err || line_err !== m_line_err) begin
         errors++; $display("FAIL frame_err_set: got fe=%b le=%b expected fe=%b le=%b",
                            frame_err, line_err, m_frame_err, m_line_err);
      end
      send_frame(2, -1);
      checks++;
      if (frame_err !== 1'b1) begin
         errors++; $display("FAIL frame_err_sticky: got %b expected 1", frame_err);
      end
      checks++;
      if (got_pix.size() !== exp_pix.size() || pix_diff() != -1) begin
         errors++; $display("FAIL frame_err_pixels: got %0d expected %0d",
                            got_pix.size(), exp_pix.size());
      end
   endtask

   task automatic test_odd_line();
      clear_log();
      send_frame(2, 0);
      checks++;
      if (got_pix.size() !== exp_pix.size() || pix_diff() != -1) begin
         errors++; $display("FAIL odd_pixels: got %0d expected %0d",
                            got_pix.size(), exp_pix.size());
      end
      checks++;
      if (line_err !== m_line_err) begin
         errors++; $display("FAIL odd_line_err: got %b expected %b", line_err, m_line_err);
      end
      send_frame(2, -1);
      checks++;
      if (line_err !== 1'b1) begin
         errors++; $display("FAIL odd_line_err_sticky: got %b expected 1", line_err);
      end
   endtask

   task automatic test_restart();
      logic [7:0] b;
      logic [7:0] hi;
      hi = 8'd0;
      clear_log();
      send_line(2 * H_PIXELS);
      for (int i = 0; i < 2 * H_PIXELS; i++) begin
         @(negedge clk);
         b = 8'($urandom_range(0, 255));
         cam_href    = 1'b1;
         cam_data    = b;
         camera_rstn = (i == 5) ? 1'b0 : 1'b1;
         if (i < 4) begin
            if (i % 2 == 0) hi = b;
            else exp_pix.push_back({hi, b});
         end
         if (i == 5) model_restart();
      end
      @(negedge clk);
      cam_href = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({capturing, line_err, frame_err} !== 3'b000) begin
         errors++; $display("FAIL restart_clear: got %b expected 000",
                            {capturing, line_err, frame_err});
      end
      send_vsync();
      send_frame(2, -1);
      send_frame(2, -1);
      checks++;
      if (capturing !== m_cap) begin
         errors++; $display("FAIL restart_rewait: got %b expected %b", capturing, m_cap);
      end
      send_frame(2, -1);
      checks++;
      if (got_pix.size() !== exp_pix.size() || pix_diff() != -1) begin
         errors++; $display("FAIL restart_pixels: got %0d expected %0d",
                            got_pix.size(), exp_pix.size());
      end
      checks++;
      if (got_fs !== exp_fs || got_fd !== exp_fd) begin
         errors++; $display("FAIL restart_strobes: got fs=%0d fd=%0d expected fs=%0d fd=%0d",
                            got_fs, got_fd, exp_fs, exp_fd);
      end
   endtask

   task automatic test_async_reset();
      logic [7:0] b;
      logic [7:0] hi;
      int         first_new;
      hi = 8'd0;
      clear_log();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         b = 8'($urandom_range(0, 255));
         cam_href = 1'b1;
         cam_data = b;
         if (i == 0) hi = b;
         if (i == 1) exp_pix.push_back({hi, b});
      end
      @(posedge clk);
      @(posedge clk);
      #2;
      checks++;
      if (capturing !== 1'b1) begin
         errors++; $display("FAIL async_precondition: got %b expected 1", capturing);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({camera_en, camera_data, frame_start, frame_done, capturing, line_err, frame_err} !== 22'd0) begin
         errors++; $display("FAIL async_outputs: got en=%b data=%h st=%b%b%b%b%b expected all 0",
                            camera_en, camera_data, frame_start, frame_done,
                            capturing, line_err, frame_err);
      end
      cam_href = 1'b0;
      cam_data = 8'd0;
      model_restart();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      first_new = exp_pix.size();
      send_vsync();
      send_frame(2, -1);
      send_frame(2, -1);
      send_frame(2, -1);
      checks++;
      if (got_pix.size() !== exp_pix.size() || pix_diff() != -1) begin
         errors++; $display("FAIL async_pixels: got %0d expected %0d",
                            got_pix.size(), exp_pix.size());
      end
      checks++;
      if (got_pix.size() <= first_new || got_pix[first_new] !== exp_pix[first_new]) begin
         errors++; $display("FAIL async_first_pixel: got %h expected %h",
                            (got_pix.size() <= first_new) ? 16'hxxxx : got_pix[first_new],
                            exp_pix[first_new]);
      end
      checks++;
      if (got_fs !== exp_fs || got_fd !== exp_fd) begin
         errors++; $display("FAIL async_strobes: got fs=%0d fd=%0d expected fs=%0d fd=%0d",
                            got_fs, got_fd, exp_fs, exp_fd);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_frame_err();
      test_odd_line();
      test_restart();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
